muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It implements MIPS MULT, MULTU, DIV, DIVU, MFHI/MFLO and MTHI/MTLO. The unit sits beside the single-cycle ALU in the datapath and takes the same rs/rt operand buses. The controller issues a one-cycle start, stalls on busy, and reads results through hi/lo.

---
 rtl/muldiv_if.sv | 16 +
 rtl/muldiv_unit.sv | 107 ++++++++++
 tb/tb_muldiv_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: operand, MT-write and result bundle between the controller and the multiply/divide unit
interface muldiv_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wd;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   modport master (output start, op, a, b, hi_we, lo_we, wd, input busy, done, hi, lo);
   modport slave (input start, op, a, b, hi_we, lo_we, wd, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO writes
module muldiv_unit #(parameter int WIDTH = 32) (
   input  logic     clk,
   input  logic     reset,
   muldiv_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic               sgn, ge;
   logic [WIDTH-1:0]   a_mag, b_mag, diff, quo, rem;
   logic [WIDTH:0]     sum, win;
   logic [2*WIDTH-1:0] prod;
   always_comb begin
      sgn   = ~bus.op[0];
      a_mag = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_mag = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
      // restoring step: partial remainder with next dividend bit shifted in
      win   = acc_q[2*WIDTH-1:WIDTH-1];
      ge    = win >= {1'b0, b_q};
      diff  = ge ? WIDTH'(win - {1'b0, b_q}) : win[WIDTH-1:0];
      prod  = neg_q ? -acc_q : acc_q;
      quo   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      hi_d    = (!busy_q && bus.hi_we) ? bus.wd : hi_q;
      lo_d    = (!busy_q && bus.lo_we) ? bus.wd : lo_q;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = CALC;
            busy_d  = 1'b1;
            cnt_d   = '0;
            div_d   = bus.op[1];
            neg_d   = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rneg_d  = sgn & bus.a[WIDTH-1];
            dz_d    = bus.op[1] && (bus.b == '0);
            a_d     = bus.a;
            b_d     = b_mag;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
         end
         CALC: begin
            acc_d = div_q ? {diff, acc_q[WIDTH-2:0], ge}
                  : acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            hi_d    = !div_q ? prod[2*WIDTH-1:WIDTH] : dz_q ? a_q : rem;
            lo_d    = !div_q ? prod[WIDTH-1:0] : dz_q ? {WIDTH{1'b1}} : quo;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit
module tb_muldiv_unit;
   typedef struct {
      string       tag;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_assert = 0;
   int n_fail = 0;
   int done_cnt = 0;
   exp_t sb[$];
   logic [31:0] saved;
   muldiv_if #(.WIDTH(32)) bus();
   muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   always @(negedge clk) if (bus.done === 1'b1) begin
      exp_t e;
      done_cnt++;
      n_assert++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL unexpected_done: got %0d queued expected >0", sb.size());
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.tag, "_hi"}, bus.hi, e.hi);
         chk({e.tag, "_lo"}, bus.lo, e.lo);
      end
   end
   task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic mtlo = 1'b0,
                        input logic [31:0] wdv = 32'h0);
      exp_t e;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = op;
      bus.a = a;
      bus.b = b;
      bus.lo_we = mtlo;
      bus.wd = wdv;
      e.tag = tag;
      e.hi = eh;
      e.lo = el;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.lo_we = 1'b0;
   endtask
   task automatic wait_done(input string tag, input int k0);
      int k, bc;
      k = k0;
      bc = k0;
      do begin
         @(negedge clk);
         k++;
         if (bus.busy === 1'b1) bc++;
      end while (bus.done !== 1'b1 && k < 40);
      chk({tag, "_latency"}, 32'(k - 1), 32'd33);
      chk({tag, "_busy_cycles"}, 32'(bc), 32'd33);
      @(negedge clk);
      chk({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.op = 2'b00;
      bus.a = '0;
      bus.b = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wd = '0;
      repeat (2) @(negedge clk);
      chk("rst_hi", bus.hi, 32'h0);
      chk("rst_lo", bus.lo, 32'h0);
      chk("rst_busy", {31'b0, bus.busy}, 32'h0);
      chk("rst_done", {31'b0, bus.done}, 32'h0);
      reset = 1'b0;
      issue("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      wait_done("multu_max", 0);
      issue("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
      wait_done("mult_neg", 0);
      issue("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
      wait_done("divu_100_7", 0);
      issue("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      wait_done("div_m7_2", 0);
      issue("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
      wait_done("div_min_m1", 0);
      issue("divu_by0", 2'b11, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF);
      wait_done("divu_by0", 0);
      issue("div_by0", 2'b10, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF);
      wait_done("div_by0", 0);
      @(negedge clk);
      bus.hi_we = 1'b1;
      bus.wd = 32'hAAAA5555;
      @(posedge clk);
      #1;
      bus.hi_we = 1'b0;
      chk("mthi_hi", bus.hi, 32'hAAAA5555);
      chk("mthi_lo_kept", bus.lo, 32'hFFFFFFFF);
      issue("mtlo_start", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 32'h5A5A5A5A);
      chk("mtlo_with_start", bus.lo, 32'h5A5A5A5A);
      chk("mtlo_hi_kept", bus.hi, 32'hAAAA5555);
      wait_done("mtlo_start", 0);
      saved = bus.lo;
      issue("multu_2_3", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6);
      repeat (9) @(negedge clk);
      bus.start = 1'b1;
      bus.op = 2'b11;
      bus.a = 32'd50;
      bus.b = 32'd5;
      bus.lo_we = 1'b1;
      bus.wd = 32'h0000DEAD;
      @(negedge clk);
      bus.start = 1'b0;
      bus.lo_we = 1'b0;
      chk("busy_mtlo_dropped", bus.lo, saved);
      wait_done("multu_2_3", 10);
      chk("done_count_9", 32'(done_cnt), 32'd9);
      issue("mult_abort", 2'b00, 32'h12345678, 32'd3, 32'h0, 32'h0);
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_hi", bus.hi, 32'h0);
      chk("abort_lo", bus.lo, 32'h0);
      chk("abort_busy", {31'b0, bus.busy}, 32'h0);
      chk("abort_done", {31'b0, bus.done}, 32'h0);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt), 32'd9);
      issue("multu_5_5", 2'b01, 32'd5, 32'd5, 32'd0, 32'd25);
      wait_done("multu_5_5", 0);
      chk("done_count_10", 32'(done_cnt), 32'd10);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
